preproc_axil_regs: RTL and testbench

AXI4-Lite responder exposing the preprocessing stage's control and status registers to the processor-side bus. It terminates the AXI-Lite transactions issued on the AXI clock domain. It drives the static configuration (DC offset, source select, enable) into the preprocessing datapath, and it reports a sticky saturation flag back.

---
 rtl/preproc_regs_pkg.sv | 30 +++
 rtl/preproc_axil_regs.sv | 142 ++++++++++++++
 tb/tb_preproc_axil_regs.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/preproc_regs_pkg.sv
// preproc_regs_pkg: register map, reset values and bus constants shared by the
// preprocessing control/status register block.
package preproc_regs_pkg;

    localparam logic [1:0] A_OFFSET     = 2'd0;
    localparam logic [1:0] A_SEL_SOURCE = 2'd1;
    localparam logic [1:0] A_CTRL       = 2'd2;
    localparam logic [1:0] A_STATUS     = 2'd3;

    localparam logic [15:0] OFFSET_RST     = 16'h0000;
    localparam logic [4:0]  SEL_SOURCE_RST = 5'b00000;
    localparam logic        ENABLE_RST     = 1'b0;
    localparam logic        SAT_RST        = 1'b0;

    localparam int ENABLE_BIT   = 0;
    localparam int SOFT_RST_BIT = 1;
    localparam int SAT_BIT      = 0;

    localparam logic [1:0] OKAY = 2'b00;

    localparam logic W_IDLE = 1'b0;
    localparam logic W_RESP = 1'b1;
    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/preproc_axil_regs.sv
// preproc_axil_regs: AXI4-Lite responder for the preprocessing stage's
// configuration (offset, source select, enable, soft reset) and sticky SAT status.
module preproc_axil_regs
    import preproc_regs_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int WSTRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  s_axil_awaddr,
    input  logic                   s_axil_awvalid,
    output logic                   s_axil_awready,
    input  logic [DATA_WIDTH-1:0]  s_axil_wdata,
    input  logic [WSTRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                   s_axil_wvalid,
    output logic                   s_axil_wready,
    output logic [1:0]             s_axil_bresp,
    output logic                   s_axil_bvalid,
    input  logic                   s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]  s_axil_araddr,
    input  logic                   s_axil_arvalid,
    output logic                   s_axil_arready,
    output logic [DATA_WIDTH-1:0]  s_axil_rdata,
    output logic [1:0]             s_axil_rresp,
    output logic                   s_axil_rvalid,
    input  logic                   s_axil_rready,
    output logic [15:0]            offset_o,
    output logic [4:0]             sel_source_o,
    output logic                   enable_o,
    output logic                   soft_rst_o,
    input  logic                   sat_flag_i
);

    logic                   wstate_q, wstate_d;
    logic                   aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0]  aw_addr_q, aw_addr_d;
    logic                   w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0]  w_data_q, w_data_d;
    logic [WSTRB_WIDTH-1:0] w_strb_q, w_strb_d;
    logic                   rstate_q, rstate_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [15:0]            offset_q, offset_d;
    logic [4:0]             sel_q, sel_d;
    logic                   enable_q, enable_d;
    logic                   soft_rst_q, soft_rst_d;
    logic                   sat_q, sat_d;

    logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic                   wr_off, wr_sel, wr_ctrl, wr_stat;
    logic [ADDR_WIDTH-1:0]  cm_addr;
    logic [DATA_WIDTH-1:0]  cm_data;
    logic [WSTRB_WIDTH-1:0] cm_strb;
    logic [31:0]            mask;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic                   unused_bits;

    assign s_axil_awready = (wstate_q == W_IDLE) && !aw_full_q;
    assign s_axil_wready  = (wstate_q == W_IDLE) && !w_full_q;
    assign s_axil_bvalid  = (wstate_q == W_RESP);
    assign s_axil_bresp   = OKAY;
    assign s_axil_arready = (rstate_q == R_IDLE);
    assign s_axil_rvalid  = (rstate_q == R_DATA);
    assign s_axil_rresp   = OKAY;
    assign s_axil_rdata   = rdata_q;
    assign offset_o       = offset_q;
    assign sel_source_o   = sel_q;
    assign enable_o       = enable_q;
    assign soft_rst_o     = soft_rst_q;
    assign unused_bits    = ^{cm_addr[1:0], cm_data[DATA_WIDTH-1:16], mask[31:16], s_axil_araddr[1:0]};

    always_comb begin
        aw_hs   = s_axil_awvalid && s_axil_awready;
        w_hs    = s_axil_wvalid && s_axil_wready;
        b_hs    = s_axil_bvalid && s_axil_bready;
        ar_hs   = s_axil_arvalid && s_axil_arready;
        r_hs    = s_axil_rvalid && s_axil_rready;
        // A channel arriving this cycle bypasses its holding register so a
        // simultaneous AW+W commits on the handshake edge itself.
        cm_addr = aw_full_q ? aw_addr_q : s_axil_awaddr;
        cm_data = w_full_q ? w_data_q : s_axil_wdata;
        cm_strb = w_full_q ? w_strb_q : s_axil_wstrb;
        commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs);
        mask    = strb_mask(cm_strb);
        wr_off  = commit && (cm_addr[3:2] == A_OFFSET);
        wr_sel  = commit && (cm_addr[3:2] == A_SEL_SOURCE);
        wr_ctrl = commit && (cm_addr[3:2] == A_CTRL);
        wr_stat = commit && (cm_addr[3:2] == A_STATUS);
        aw_full_d  = commit ? 1'b0 : (aw_hs ? 1'b1 : aw_full_q);
        aw_addr_d  = aw_hs ? s_axil_awaddr : aw_addr_q;
        w_full_d   = commit ? 1'b0 : (w_hs ? 1'b1 : w_full_q);
        w_data_d   = w_hs ? s_axil_wdata : w_data_q;
        w_strb_d   = w_hs ? s_axil_wstrb : w_strb_q;
        wstate_d   = commit ? W_RESP : (b_hs ? W_IDLE : wstate_q);
        offset_d   = wr_off ? ((offset_q & ~mask[15:0]) | (cm_data[15:0] & mask[15:0])) : offset_q;
        sel_d      = wr_sel ? ((sel_q & ~mask[4:0]) | (cm_data[4:0] & mask[4:0])) : sel_q;
        enable_d   = (wr_ctrl && cm_strb[0]) ? cm_data[ENABLE_BIT] : enable_q;
        soft_rst_d = wr_ctrl && cm_strb[0] && cm_data[SOFT_RST_BIT];
        // A new saturation event overrides a clear committed in the same cycle.
        sat_d      = sat_flag_i || (sat_q && !(wr_stat && cm_strb[0] && cm_data[SAT_BIT]));
        rd_word    = (s_axil_araddr[3:2] == A_OFFSET)     ? {{(DATA_WIDTH-16){1'b0}}, offset_q} :
                     (s_axil_araddr[3:2] == A_SEL_SOURCE) ? {{(DATA_WIDTH-5){1'b0}}, sel_q} :
                     (s_axil_araddr[3:2] == A_CTRL)       ? {{(DATA_WIDTH-1){1'b0}}, enable_q} :
                                                            {{(DATA_WIDTH-1){1'b0}}, sat_q};
        rdata_d    = ar_hs ? rd_word : rdata_q;
        rstate_d   = ar_hs ? R_DATA : (r_hs ? R_IDLE : rstate_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q   <= W_IDLE;
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            rstate_q   <= R_IDLE;
            rdata_q    <= '0;
            offset_q   <= OFFSET_RST;
            sel_q      <= SEL_SOURCE_RST;
            enable_q   <= ENABLE_RST;
            soft_rst_q <= 1'b0;
            sat_q      <= SAT_RST;
        end else begin
            wstate_q   <= wstate_d;
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            rstate_q   <= rstate_d;
            rdata_q    <= rdata_d;
            offset_q   <= offset_d;
            sel_q      <= sel_d;
            enable_q   <= enable_d;
            soft_rst_q <= soft_rst_d;
            sat_q      <= sat_d;
        end
    end

endmodule

// File: tb/tb_preproc_axil_regs.sv
// tb_preproc_axil_regs: directed and randomized AXI-Lite traffic checked against
// a register-map model of the preprocessing control/status block.
module tb_preproc_axil_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_axil_awaddr;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [3:0]  s_axil_araddr;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic [15:0] offset_o;
    logic [4:0]  sel_source_o;
    logic        enable_o;
    logic        soft_rst_o;
    logic        sat_flag_i;

    int checks = 0;
    int errors = 0;
    int sr_cnt = 0;

    logic [15:0] m_off;
    logic [4:0]  m_sel;
    logic        m_en;
    logic        m_sat;

    preproc_axil_regs dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .offset_o(offset_o), .sel_source_o(sel_source_o), .enable_o(enable_o),
        .soft_rst_o(soft_rst_o), .sat_flag_i(sat_flag_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (soft_rst_o) sr_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {16'h0, m_off};
            2'd1:    return {27'h0, m_sel};
            2'd2:    return {31'h0, m_en};
            default: return {31'h0, m_sat};
        endcase
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input bit sat_now);
        logic [31:0] nv;
        nv = exp_read(a);
        for (int b = 0; b < 4; b++) if (s[b]) nv[8*b +: 8] = d[8*b +: 8];
        case (a[3:2])
            2'd0:    m_off = nv[15:0];
            2'd1:    m_sel = nv[4:0];
            2'd2:    m_en = nv[0];
            default: if (s[0] && d[0]) m_sat = 1'b0;
        endcase
        if (sat_now) m_sat = 1'b1;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "/offset"}, {16'h0, offset_o}, {16'h0, m_off});
        chk({tag, "/sel"}, {27'h0, sel_source_o}, {27'h0, m_sel});
        chk({tag, "/enable"}, {31'h0, enable_o}, {31'h0, m_en});
    endtask

    task automatic model_reset();
        m_off = 16'h0;
        m_sel = 5'h0;
        m_en  = 1'b0;
        m_sat = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly, input bit sat_now);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_hs, w_hs, b_hs;
        int n = 0;
        int sr0;
        bit exp_sr;
        sr0 = sr_cnt;
        exp_sr = (a[3:2] == 2'd2) && s[0] && d[1];
        s_axil_awaddr = a;
        s_axil_wdata = d;
        s_axil_wstrb = s;
        s_axil_bready = 1'b0;
        sat_flag_i = sat_now;
        while (!(aw_done && w_done) && n < 40) begin
            s_axil_awvalid = !aw_done && n >= aw_dly;
            s_axil_wvalid = !w_done && n >= w_dly;
            @(negedge clk);
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs = s_axil_wvalid && s_axil_wready;
            @(posedge clk);
            #1;
            sat_flag_i = 1'b0;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            if (w_hs && !aw_done) chk("wready_drop", {31'h0, s_axil_wready}, 32'h0);
            if (aw_hs && !w_done) chk("awready_drop", {31'h0, s_axil_awready}, 32'h0);
            n++;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid = 1'b0;
        chk("write_addr_data_accept", {31'h0, aw_done && w_done}, 32'h1);
        model_write(a, d, s, sat_now);
        chk("bvalid_next_cycle", {31'h0, s_axil_bvalid}, 32'h1);
        chk("bresp", {30'h0, s_axil_bresp}, 32'h0);
        chk_outs("after_write");
        chk("soft_rst_after_commit", {31'h0, soft_rst_o}, {31'h0, exp_sr});
        n = 0;
        b_hs = 0;
        while (!b_hs && n < 40) begin
            s_axil_bready = (n >= b_dly);
            @(negedge clk);
            b_hs = s_axil_bvalid && s_axil_bready;
            if (!b_hs) begin
                chk("bvalid_hold", {31'h0, s_axil_bvalid}, 32'h1);
                chk("awready_while_bvalid", {31'h0, s_axil_awready}, 32'h0);
                chk("wready_while_bvalid", {31'h0, s_axil_wready}, 32'h0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        s_axil_bready = 1'b0;
        chk("b_handshake", {31'h0, b_hs}, 32'h1);
        chk("bvalid_cleared", {31'h0, s_axil_bvalid}, 32'h0);
        chk("soft_rst_cycles", sr_cnt - sr0, {31'h0, exp_sr});
    endtask

    task automatic axi_read(input logic [3:0] a, input int r_dly, input string tag);
        logic [31:0] exp;
        bit hs = 0;
        int n = 0;
        exp = '0;
        s_axil_araddr = a;
        s_axil_arvalid = 1'b1;
        while (!hs && n < 40) begin
            @(negedge clk);
            hs = s_axil_arvalid && s_axil_arready;
            exp = exp_read(a);
            @(posedge clk);
            #1;
            n++;
        end
        s_axil_arvalid = 1'b0;
        chk("ar_handshake", {31'h0, hs}, 32'h1);
        chk("rvalid_next_cycle", {31'h0, s_axil_rvalid}, 32'h1);
        chk(tag, s_axil_rdata, exp);
        chk("rresp", {30'h0, s_axil_rresp}, 32'h0);
        n = 0;
        hs = 0;
        while (!hs && n < 40) begin
            s_axil_rready = (n >= r_dly);
            @(negedge clk);
            hs = s_axil_rvalid && s_axil_rready;
            if (!hs) chk("rdata_hold", s_axil_rdata, exp);
            @(posedge clk);
            #1;
            n++;
        end
        s_axil_rready = 1'b0;
        chk("r_handshake", {31'h0, hs}, 32'h1);
        chk("rvalid_cleared", {31'h0, s_axil_rvalid}, 32'h0);
    endtask

    task automatic pulse_sat();
        sat_flag_i = 1'b1;
        @(posedge clk);
        #1;
        sat_flag_i = 1'b0;
        m_sat = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s_axil_awaddr = '0; s_axil_awvalid = 0; s_axil_wdata = '0; s_axil_wstrb = '0;
        s_axil_wvalid = 0; s_axil_bready = 0; s_axil_araddr = '0; s_axil_arvalid = 0;
        s_axil_rready = 0; sat_flag_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {31'h0, s_axil_awready}, 32'h1);
        chk("rst_wready", {31'h0, s_axil_wready}, 32'h1);
        chk("rst_arready", {31'h0, s_axil_arready}, 32'h1);
        chk("rst_bvalid", {31'h0, s_axil_bvalid}, 32'h0);
        chk("rst_rvalid", {31'h0, s_axil_rvalid}, 32'h0);
        chk("rst_rdata", s_axil_rdata, 32'h0);
        chk("rst_soft", {31'h0, soft_rst_o}, 32'h0);
        chk_outs("rst");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0, "reset_readback");

        axi_write(4'h0, 32'h0000ABCD, 4'b1111, 0, 0, 0, 0);
        chk("offset_abcd", {16'h0, offset_o}, 32'hABCD);
        axi_write(4'h0, 32'h00000012, 4'b0001, 0, 0, 0, 0);
        chk("offset_ab12", {16'h0, offset_o}, 32'hAB12);

        axi_write(4'h4, 32'h00000013, 4'b1111, 3, 0, 0, 0);
        chk("sel_13", {27'h0, sel_source_o}, 32'h13);
        axi_read(4'h4, 0, "sel_readback");
        chk("sel_rdata_13", s_axil_rdata, 32'h13);

        axi_write(4'h8, 32'h00000003, 4'b1111, 0, 0, 5, 0);
        chk("enable_set", {31'h0, enable_o}, 32'h1);
        axi_read(4'h8, 2, "ctrl_readback");
        chk("ctrl_rdata_1", s_axil_rdata, 32'h1);

        pulse_sat();
        axi_read(4'hC, 0, "sat_set");
        chk("status_1", s_axil_rdata, 32'h1);
        axi_write(4'hC, 32'h1, 4'b1111, 0, 0, 0, 1);
        axi_read(4'hC, 0, "sat_set_wins");
        chk("status_set_wins", s_axil_rdata, 32'h1);
        axi_write(4'hC, 32'h1, 4'b1111, 0, 0, 0, 0);
        axi_read(4'hC, 0, "sat_cleared");
        chk("status_cleared", s_axil_rdata, 32'h0);

        axi_write(4'h0, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 0);
        chk("strobe_zero_noop", {16'h0, offset_o}, 32'hAB12);
        axi_write(4'h1, 32'h00770000, 4'b0100, 1, 2, 1, 0);

        for (int i = 0; i < 60; i++) begin
            int op;
            op = int'($urandom_range(0, 5));
            if (op < 3)
                axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), 0);
            else if (op < 5)
                axi_read(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "rand_read");
            else
                pulse_sat();
        end

        axi_write(4'h0, 32'h00005A5A, 4'b1111, 0, 0, 0, 0);
        s_axil_araddr = 4'h0;
        s_axil_arvalid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        s_axil_arvalid = 1'b0;
        chk("pre_rst_rvalid", {31'h0, s_axil_rvalid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_rvalid", {31'h0, s_axil_rvalid}, 32'h0);
        chk("midrst_arready", {31'h0, s_axil_arready}, 32'h1);
        chk("midrst_rdata", s_axil_rdata, 32'h0);
        chk_outs("midrst");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 1, "post_rst_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
